// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds countdown with start/pause/resume.
// One decrement of seconds_left per CYCLES_PER_SECOND cycles spent in RUN.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN. When it is defined, expiry
// reloads the last loaded value and keeps running instead of entering DONE.
module countdown_timer #(
  parameter int CYCLES_PER_SECOND = 25_000_000,
  parameter int SEC_W             = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SEC_W-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [SEC_W-1:0] seconds_left,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam int             CW      = $clog2(CYCLES_PER_SECOND);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYCLES_PER_SECOND - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             exp_q, exp_d;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [SEC_W-1:0] reload_q;

  // Remember the most recent load value so expiry can restart from it.
  always_ff @(posedge clk) begin
    if (reset)     reload_q <= '0;
    else if (load) reload_q <= load_value;
  end
`endif

  // Next-state logic: load beats pause, pause beats start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sec_d   = sec_q;
    exp_d   = 1'b0;
    if (load) begin
      // Any partial second in flight is discarded.
      sec_d   = load_value;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          // start together with pause is a no-op here; zero never starts.
          if (start && !pause && (sec_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;              // counter and seconds held
          end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (sec_q == SEC_W'(1)) begin
              exp_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              sec_d = reload_q;           // stay in RUN, counter restarts at 0
`else
              sec_d   = '0;
              state_d = DONE;
`endif
            end else begin
              sec_d = sec_q - SEC_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;                        // DONE: only load or reset leaves
      endcase
    end
  end

  // State, counters and expiry pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sec_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sec_q   <= sec_d;
      exp_q   <= exp_d;
    end
  end

  assign seconds_left = sec_q;
  assign expired      = exp_q;
  assign running      = (state_q == RUN);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CYCLES_PER_SECOND=4, SEC_W=6.
// A vector table covers the basic countdown, ignored controls and priority;
// hand sequences cover pause/resume, load mid-run and reset mid-run.
module tb_countdown_timer;

  localparam int CPS   = 4;
  localparam int SEC_W = 6;

  logic             clk = 1'b0;
  logic             reset, load, start, pause;
  logic [SEC_W-1:0] load_value;
  logic [SEC_W-1:0] seconds_left;
  logic             running, done, expired;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.CYCLES_PER_SECOND(CPS), .SEC_W(SEC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .pause        (pause),
    .seconds_left (seconds_left),
    .running      (running),
    .done         (done),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ld, st, pa;
    logic [5:0] lv;
    logic [5:0] e_sec;
    logic       e_run, e_done, e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ld, input logic [5:0] lv,
                     input logic st, input logic pa, input logic [5:0] e_sec,
                     input logic e_run, input logic e_done, input logic e_exp);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.pa = pa;
    v.e_sec = e_sec; v.e_run = e_run; v.e_done = e_done; v.e_exp = e_exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] e_sec,
                       input logic e_run, input logic e_done, input logic e_exp);
    checks++;
    if (seconds_left !== e_sec || running !== e_run || done !== e_done ||
        expired !== e_exp) begin
      errors++;
      $display("FAIL %s: got sec=%0d run=%b done=%b exp=%b, expected sec=%0d run=%b done=%b exp=%b",
               name, seconds_left, running, done, expired, e_sec, e_run, e_done, e_exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge sample them, then settle.
  task automatic step(input logic rst, input logic ld, input logic [5:0] lv,
                      input logic st, input logic pa);
    reset = rst; load = ld; load_value = lv; start = st; pause = pa;
    @(posedge clk);
    #1;
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
    @(negedge clk);

`ifndef COUNTDOWN_AUTORELOAD_EN
    // rst ld lv st pa | sec run done exp
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);              // reset state
    add(0, 1, 3, 0, 0,  3, 0, 0, 0);              // load 3
    add(0, 0, 0, 1, 0,  3, 1, 0, 0);              // start edge
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0,  2, 1, 0, 0);              // start+4
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 0);              // start+8
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1);              // start+12: expiry pulse
    add(0, 0, 0, 0, 0,  0, 0, 1, 0);              // pulse is one cycle
    add(0, 0, 0, 1, 0,  0, 0, 1, 0);              // start in DONE ignored
    add(0, 0, 0, 0, 1,  0, 0, 1, 0);              // pause in DONE ignored
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);              // load 0 leaves DONE
    add(0, 0, 0, 1, 0,  0, 0, 0, 0);              // start with 0 ignored
    add(0, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 4, 0, 0,  4, 0, 0, 0);
    add(0, 0, 0, 1, 0,  4, 1, 0, 0);
    add(0, 0, 0, 0, 0,  4, 1, 0, 0);
    add(0, 1, 5, 1, 0,  5, 0, 0, 0);              // load beats start in RUN
    add(0, 0, 0, 0, 0,  5, 0, 0, 0);
    add(0, 0, 0, 1, 1,  5, 0, 0, 0);              // start+pause in IDLE: no-op
    add(0, 0, 0, 0, 0,  5, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa);
      check($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_run,
            vecs[i].e_done, vecs[i].e_exp);
    end

    // Pause after two RUN cycles, hold ten cycles, resume.
    step(0, 1, 2, 0, 0); check("pr_load", 2, 0, 0, 0);
    step(0, 0, 0, 1, 0); check("pr_start", 2, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("pr_run2", 2, 1, 0, 0);
    step(0, 0, 0, 0, 1); check("pr_pause", 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("pr_hold%0d", i), 2, 0, 0, 0);
    end
    step(0, 0, 0, 1, 1); check("pr_startpause", 2, 0, 0, 0);
    step(0, 0, 0, 1, 0); check("pr_resume", 2, 1, 0, 0);
    step(0, 0, 0, 0, 0); check("pr_res1", 2, 1, 0, 0);
    step(0, 0, 0, 0, 0); check("pr_res2_dec", 1, 1, 0, 0);
    step(0, 0, 0, 1, 1); check("pr_pause_wins", 1, 0, 0, 0);

    // Load mid-RUN discards the partial second.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0); check("lm_reload", 3, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    check("lm_nodec", 3, 1, 0, 0);
    step(0, 0, 0, 0, 0); check("lm_dec", 2, 1, 0, 0);

    // Reset six cycles into a run.
    step(0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    check("rm_before", 6, 1, 0, 0);
    step(1, 0, 0, 0, 0); check("rm_reset", 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); check("rm_idle", 0, 0, 0, 0);
`else
    // Auto-reload: load 2, start; expiry every 8 RUN cycles, never DONE.
    step(1, 0, 0, 0, 0); check("ar_reset", 0, 0, 0, 0);
    step(0, 1, 2, 0, 0); check("ar_load", 2, 0, 0, 0);
    step(0, 0, 0, 1, 0); check("ar_start", 2, 1, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      step(0, 0, 0, 0, 0);
      check($sformatf("ar_k%0d", k), ((k / 4) % 2 == 1) ? 6'd1 : 6'd2,
            1'b1, 1'b0, (k % 8 == 0));
    end
    step(1, 0, 0, 0, 0); check("ar_rst", 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
